// File: rtl/alu_ctrl_md.sv
// ALU control decode plus an iterative multiply/divide sequencer owning HI/LO.
// Optional MD_EARLY_EXIT_EN: a multiply leaves RUN once the remaining multiplier is zero.
module alu_ctrl_md #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        fun,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] alu_ctr,
  output logic              illegal,
  output logic              stall,
  output logic              md_busy,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [3:0] C_NOP  = 4'd0,  C_ADD = 4'd1,  C_SUB = 4'd2,  C_AND = 4'd3,
                         C_OR   = 4'd4,  C_XOR = 4'd5,  C_LUI = 4'd6,  C_SLT = 4'd7,
                         C_NOR  = 4'd8,  C_SLTU = 4'd9, C_SLL = 4'd10, C_SRL = 4'd11,
                         C_SRA  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_div, neg_p, neg_r, dz;
  logic [PW-1:0]     acc, addend;
  logic [WIDTH-1:0]  shreg;

  logic [3:0]        code;
  logic              md_class, md_req, md_start, mt_req, run_last;
  logic              sgn_a, sgn_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    rem_sh, diff;
  logic [PW-1:0]     acc_step, add_step, prod;
  logic [WIDTH-1:0]  sh_step, quo, rem;

  // Instruction decode: ALU code, illegal funct, and MD-class detection
  always_comb begin
    code     = C_NOP;
    illegal  = 1'b0;
    md_class = 1'b0;
    case (alu_op)
      3'b000: code = C_ADD;
      3'b001: begin
        case (fun)
          6'b100000, 6'b100001: code = C_ADD;
          6'b100010, 6'b100011: code = C_SUB;
          6'b100100:            code = C_AND;
          6'b100101:            code = C_OR;
          6'b100110:            code = C_XOR;
          6'b100111:            code = C_NOR;
          6'b101010:            code = C_SLT;
          6'b101011:            code = C_SLTU;
          6'b000000:            code = C_SLL;
          6'b000010:            code = C_SRL;
          6'b000011:            code = C_SRA;
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010001, 6'b010010, 6'b010011: md_class = 1'b1;
          default:              illegal = 1'b1;
        endcase
      end
      3'b010: code = C_OR;
      3'b011: code = C_XOR;
      3'b100: code = C_SUB;
      3'b101: code = C_SLT;
      3'b110: code = C_SLTU;
      default: code = C_LUI;
    endcase
  end

  assign alu_ctr  = CTRL_W'(code);
  assign md_req   = valid & (alu_op == 3'b001) & md_class;
  assign md_start = md_req & (fun[5:2] == 4'b0110) & (state == S_IDLE);
  assign mt_req   = md_req & (fun[5:2] == 4'b0100) & fun[0] & (state == S_IDLE);
  assign stall    = md_req & md_busy;

  // fun[0] set means unsigned; signed ops work on magnitudes
  assign sgn_a = ~fun[0] & src_a[WIDTH-1];
  assign sgn_b = ~fun[0] & src_b[WIDTH-1];
  assign mag_a = sgn_a ? -src_a : src_a;
  assign mag_b = sgn_b ? -src_b : src_b;

`ifdef MD_EARLY_EXIT_EN
  assign run_last = (cnt == CNT_W'(WIDTH - 1)) | (~op_div & (shreg[WIDTH-1:1] == '0));
`else
  assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  // State register; md_busy tracks the registered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      md_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_busy <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (md_start) state_nxt = S_RUN;
      S_RUN:   if (run_last) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    acc_step = acc;
    add_step = addend;
    sh_step  = shreg;
    rem_sh   = '0;
    diff     = '0;
    if (op_div) begin
      rem_sh = {acc[WIDTH-1:0], shreg[WIDTH-1]};
      diff   = rem_sh - {1'b0, addend[WIDTH-1:0]};
      if (!diff[WIDTH]) begin
        acc_step = PW'(diff[WIDTH-1:0]);
        sh_step  = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = PW'(rem_sh[WIDTH-1:0]);
        sh_step  = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shreg[0]) acc_step = acc + addend;
      add_step = addend << 1;
      sh_step  = shreg >> 1;
    end
  end

  // Sign correction; divide by zero forces an all-ones quotient
  assign prod = neg_p ? -acc : acc;
  assign quo  = dz ? '1 : (neg_p ? -shreg : shreg);
  assign rem  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      addend <= '0;
      shreg  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start) begin
            cnt    <= '0;
            op_div <= fun[1];
            neg_p  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            dz     <= (src_b == '0);
            acc    <= '0;
            addend <= fun[1] ? PW'(mag_b) : PW'(mag_a);
            shreg  <= fun[1] ? mag_a : mag_b;
          end else if (mt_req) begin
            if (fun[1]) lo <= src_a;
            else        hi <= src_a;
          end
        end
        S_RUN: begin
          cnt    <= cnt + CNT_W'(1);
          acc    <= acc_step;
          addend <= add_step;
          shreg  <= sh_step;
        end
        S_FIX: begin
          if (op_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[PW-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations for decode, results, hazards and reset.
module tb_alu_ctrl_md;
  localparam int unsigned W = 32;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTHI  = 6'b010001, F_MTLO = 6'b010011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [2:0]   alu_op = 3'b000;
  logic [5:0]   fun = 6'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [3:0]   alu_ctr;
  logic         illegal, stall, md_busy;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always #5 clk = ~clk;

  alu_ctrl_md #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .alu_op(alu_op), .fun(fun),
    .src_a(src_a), .src_b(src_b), .alu_ctr(alu_ctr), .illegal(illegal),
    .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [5:0] f);
    return f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                     6'b010000, 6'b010001, 6'b010010, 6'b010011};
  endfunction

  function automatic bit is_muldiv(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  // Decode tables straight from the operation list
  function automatic void exp_decode(input logic [2:0] op, input logic [5:0] f,
                                     output int code, output bit ill);
    code = 0;
    ill  = 1'b0;
    case (op)
      3'b000: code = 1;
      3'b010: code = 4;
      3'b011: code = 5;
      3'b100: code = 2;
      3'b101: code = 7;
      3'b110: code = 9;
      3'b111: code = 6;
      default: begin
        case (f)
          6'b100000, 6'b100001: code = 1;
          6'b100010, 6'b100011: code = 2;
          6'b100100: code = 3;
          6'b100101: code = 4;
          6'b100110: code = 5;
          6'b100111: code = 8;
          6'b101010: code = 7;
          6'b101011: code = 9;
          6'b000000: code = 10;
          6'b000010: code = 11;
          6'b000011: code = 12;
          default:   ill = !is_md(f);
        endcase
      end
    endcase
  endfunction

  // Reference results using native 64-bit and signed arithmetic
  function automatic void md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint          sp;
    longint unsigned up;
    int              qs, rs;
    h = '0;
    l = '0;
    case (f)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
      end
      F_DIVU: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
        else begin
          qs = $signed(a) / $signed(b);
          rs = $signed(a) % $signed(b);
          l = 32'(qs);
          h = 32'(rs);
        end
      end
    endcase
  endfunction

  // Model: busy countdown of W+1 cycles, results land when it expires
  always @(posedge clk or posedge rst) begin : model
    logic [31:0] h, l;
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (valid && alu_op == 3'b001) begin
      if (is_muldiv(fun)) begin
        md_ref(fun, src_a, src_b, h, l);
        p_hi   <= h;
        p_lo   <= l;
        m_left <= W + 1;
      end else if (fun == F_MTHI) begin
        m_hi <= src_a;
      end else if (fun == F_MTLO) begin
        m_lo <= src_a;
      end
    end
  end

  always @(negedge clk) begin : compare
    int code;
    bit ill, exp_stall;
    exp_decode(alu_op, fun, code, ill);
    exp_stall = valid && alu_op == 3'b001 && is_md(fun) && m_left > 0;
    chk("alu_ctr", 32'(alu_ctr), 32'(code));
    chk("illegal", 32'(illegal), 32'(ill));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("md_busy", 32'(md_busy), 32'(m_left > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [2:0] op, input logic [5:0] f);
    valid  = 1'b0;
    alu_op = op;
    fun    = f;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    alu_op = 3'b001;
    fun    = f;
    src_a  = a;
    src_b  = b;
    step();
    valid  = 1'b0;
    alu_op = 3'b000;
    fun    = 6'd0;
  endtask

  // Count busy cycles until md_busy drops; ends on the negedge where it is low
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!md_busy) return;
      n++;
    end
    checks++;
    failures++;
    $display("FAIL wait_done: md_busy still high after %0d cycles", n);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(f, a, b);
    wait_done(n);
    chk({name, "_busy"}, 32'(n), 32'd33);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    step();

    // Decode spot checks
    set_dec(3'b001, 6'b101010); @(negedge clk); chk("dec_slt", 32'(alu_ctr), 32'd7); step();
    set_dec(3'b010, 6'b000000); @(negedge clk); chk("dec_or", 32'(alu_ctr), 32'd4); step();
    set_dec(3'b001, 6'b111111); @(negedge clk);
    chk("dec_bad_ctr", 32'(alu_ctr), 32'd0); chk("dec_bad_ill", 32'(illegal), 32'd1); step();
    set_dec(3'b001, F_MULT); @(negedge clk);
    chk("dec_md_ctr", 32'(alu_ctr), 32'd0); chk("dec_md_ill", 32'(illegal), 32'd0); step();
    set_dec(3'b111, 6'b100000); @(negedge clk);
    chk("dec_lui", 32'(alu_ctr), 32'd6); chk("dec_lui_ill", 32'(illegal), 32'd0); step();

    // Full funct sweep under R-type, a few under the other classes
    for (int f = 0; f < 64; f++) begin
      set_dec(3'b001, 6'(f));
      step();
    end
    for (int op = 0; op < 8; op++) begin
      set_dec(3'(op), 6'b111111);
      step();
    end
    set_dec(3'b000, 6'd0);

    // Multiply / divide results
    run_op("mult",  F_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", F_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
    run_op("divu",  F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div",   F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div0",  F_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("divov", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("mult2", F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);

    // mflo issued while busy stalls until the result is final
    issue(F_MULT, 32'd1000, 32'd3);
    step();
    valid = 1'b1; alu_op = 3'b001; fun = F_MFLO;
    @(negedge clk);
    chk("mflo_stall_on", 32'(stall), 32'd1);
    wait_done(n);
    chk("mflo_stall_off", 32'(stall), 32'd0);
    chk("mflo_lo", lo, 32'd3000);
    step();
    valid = 1'b0; alu_op = 3'b000; fun = 6'd0;
    step();

    // Second mult while busy stalls and does not restart
    issue(F_MULT, 32'd2, 32'd3);
    repeat (4) step();
    valid = 1'b1; alu_op = 3'b001; fun = F_MULT; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    chk("mult_busy_stall", 32'(stall), 32'd1);
    step();
    step();
    valid = 1'b0; alu_op = 3'b000; fun = 6'd0;
    wait_done(n);
    chk("mult_no_restart_busy", 32'(n), 32'd27);
    chk("mult_no_restart_lo", lo, 32'd6);
    chk("mult_no_restart_hi", hi, 32'd0);
    step();

    // Moves to HI/LO in IDLE
    issue(F_MTLO, 32'h0000_1234, 32'd0);
    @(negedge clk);
    chk("mtlo", lo, 32'h0000_1234);
    step();
    issue(F_MTHI, 32'h0000_ABCD, 32'd0);
    @(negedge clk);
    chk("mthi", hi, 32'h0000_ABCD);
    step();

    // Asynchronous reset in the middle of a divide
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(md_busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_after_busy", 32'(md_busy), 32'd0);
    step();
    run_op("divu_post_rst", F_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Next-generation ALU control for the single-cycle/EX-stage datapath.
- Decodes alu_op/fun into a widened ALU control code covering the full MIPS-I integer R-type set.
- Adds an iterative multiply/divide sequencer with HI/LO registers and a pipeline stall output.
- Sits between the main control unit and the ALU / register-file writeback mux.

Parameters:
WIDTH, 32, operand/HI/LO width; must be at least 4 and even.
CTRL_W, 4, width of alu_ctr; must be at least 4.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
valid  in  1  instruction present in EX this cycle.
alu_op  in  3  class code from main control.
fun  in  6  instruction funct field.
src_a  in  WIDTH  rs operand.
src_b  in  WIDTH  rt operand.
alu_ctr  out  CTRL_W  ALU operation code (combinational).
illegal  out  1  R-type with undefined funct (combinational).
stall  out  1  hold PC/IF/ID; EX instruction must retry.
md_busy  out  1  sequencer not IDLE.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- alu_ctr codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, XOR 5, LUI 6, SLT 7, NOR 8, SLTU 9, SLL 10, SRL 11, SRA 12.
- alu_op mapping: 000 ADD, 001 decode fun, 010 OR, 011 XOR, 100 SUB, 101 SLT, 110 SLTU, 111 LUI.
- fun mapping when alu_op=001:
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT; 101011 SLTU; 000000 SLL; 000010 SRL; 000011 SRA.
  - MD-class funct (mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011): alu_ctr=NOP, illegal=0.
  - Any other fun: alu_ctr=NOP, illegal=1.
- Decode is fully specified for all inputs; no latches. illegal is 0 whenever alu_op != 001.
- md_req = valid & alu_op==001 & fun is MD-class.
- stall = md_req & md_busy. A stalled instruction has no effect on hi/lo.
- FSM states:
  - IDLE: if md_req and fun is mult/multu/div/divu, capture operands at the clock edge and go to RUN with cnt=0. Signed ops store magnitudes plus result sign flags. The issuing instruction itself does not stall. mthi/mtlo in IDLE write src_a to hi/lo at the edge.
  - RUN: one radix-2 step per cycle; multiply is shift-add, divide is restoring. cnt increments; after the WIDTH-th step go to FIX.
  - FIX: apply sign correction (quotient sign = sa^sb; remainder sign = sa; product sign = sa^sb), write hi/lo, go to IDLE.
- md_busy = (state != IDLE). It is high for exactly WIDTH+1 cycles after the start edge. New hi/lo are visible in the first cycle md_busy is low.
- mfhi/mflo reads are performed by the datapath from the hi/lo outputs; stall guarantees results are final before a read.
- Divide by zero: hi=dividend (src_a), lo=all ones, full latency, no flag.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- rst asserted (any time, including mid-operation): state=IDLE, cnt=0, hi=0, lo=0, md_busy=0, stall=0 immediately. No partial result is written.

Optional Feature:
- Macro MD_EARLY_EXIT_EN.
- Defined: a multiply leaves RUN as soon as the remaining multiplier magnitude is zero, minimum 1 RUN cycle. Latency = (index of MSB of |src_b|)+2 cycles, and 2 cycles for src_b=0. Divide timing is unchanged.
- Not defined: all operations take a fixed WIDTH+1 busy cycles.

Test Plan (WIDTH=32, macro off):
1. Decode: alu_op=001,fun=101010 -> alu_ctr=7; alu_op=010 -> 4; alu_op=001,fun=111111 -> alu_ctr=0, illegal=1; alu_op=001,fun=011000 -> alu_ctr=0, illegal=0.
2. mult src_a=0xFFFFFFFD, src_b=7 -> md_busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
3. divu 100/7 -> lo=14, hi=2. div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. div 5/0 -> hi=5, lo=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Hazards: mflo with valid=1 issued 3 cycles after mult -> stall=1 until md_busy falls, then 0. A second mult issued while busy stalls and does not restart the sequencer. mtlo 0x1234 in IDLE -> lo=0x1234 next cycle.
6. Reset: rst pulsed at RUN cycle 10 of divu -> md_busy, hi, lo = 0 asynchronously. A following divu 9/4 completes with lo=2, hi=1.
